slice_demux_ctrl: RTL and testbench
===================================

// Module: slice_demux_ctrl
// PURPOSE
//  Frame sequencer and flow controller in front of slice_demux.
//  - Accepts the 256-bit compressed stream (valid/ready).
//  - Tags the PPS header words and issues in_sof before slice data.
//  - Stalls the stream when any active per-slice FIFO lacks credit.
//  - Frame length comes from chunk_size * slices_per_line * lines_per_frame.
// PARAMETERS
//  MAX_NBR_SLICES  2    number of slice FIFOs / demux outputs
//  FIFO_DEPTH      16   words per downstream slice FIFO (initial credit)
//  CREDIT_MARGIN   2    min free credits per slice to forward a word (covers demux latency)
//  PPS_WORDS       4    256-bit words per PPS (128 bytes)
//  WDOG_CYCLES     4096 stall limit in DATA; used only with the watchdog macro
// PORTS
//  clk              in  1                clock
//  rst              in  1                sync active-high reset
//  flush            in  1                sync clear of state, counters and credits; config kept
//  slices_per_line  in  10               active slices, 1..MAX_NBR_SLICES
//  chunk_size       in  16               bytes per chunk
//  lines_per_frame  in  16               chunk rows per frame
//  s_data           in  256              upstream word
//  s_valid          in  1                upstream valid
//  s_ready          out 1                upstream ready
//  in_data          out 256              to demux in_data
//  in_valid         out 1                to demux in_valid
//  in_sof           out 1                to demux in_sof
//  data_in_is_pps   out 1                to demux data_in_is_pps
//  demux_out_valid  in  MAX_NBR_SLICES   demux out_valid (slice FIFO push)
//  fifo_pop         in  MAX_NBR_SLICES   slice FIFO pops (credit return)
//  frame_done       out 1                1-cycle pulse after last frame word is forwarded
//  credit_err       out 1                sticky: push with zero credit, or pop at FIFO_DEPTH
//  wdog_err         out 1                sticky watchdog timeout
// BEHAVIOUR
//  - Reset/flush: state=IDLE. All outputs 0 (s_ready=0, in_data=0).
//    Credits=FIFO_DEPTH; counters 0; sticky errors cleared.
//  - Credits: credit[i] -= demux_out_valid[i] and += fifo_pop[i].
//    If both occur in the same cycle, credit is unchanged.
//    Saturates at 0 / FIFO_DEPTH; a saturating event sets credit_err.
//  - Handshake: a word is accepted when s_valid & s_ready.
//    Accepted words appear on in_data/in_valid exactly 1 cycle later (registered).
//    in_valid is 0 on all other cycles.
//  - s_ready=1 only in PPS, or in DATA when credit[i] >= CREDIT_MARGIN
//    for every i < slices_per_line.
//  - FSM:
//    IDLE->PPS: the cycle after reset/flush release.
//    PPS: accepts PPS_WORDS words; in_valid words carry data_in_is_pps=1.
//      After the last PPS word is accepted -> SOF.
//    SOF: one cycle; in_sof=1, in_valid=0, s_ready=0 -> DATA.
//    DATA: frame_bytes = chunk_size*slices_per_line*lines_per_frame (42-bit).
//      byte_cnt += 32 per accepted word. The word that makes byte_cnt >= frame_bytes is last.
//      After the last word -> DONE.
//    DONE: frame_done=1 for one cycle -> PPS (next frame).
//  - Zero-length frame (any size field 0): SOF still issued, then straight to DONE; no data words.
//  - flush in any state overrides everything; the in-flight registered word is dropped (in_valid=0 next cycle).
//  - slices_per_line changes are only sampled in IDLE/PPS; values > MAX_NBR_SLICES clamp to MAX_NBR_SLICES.
// CONFIGURATION
//  SLICE_DEMUX_CTRL_WATCHDOG_EN defined:
//    - A counter increments in DATA each cycle with no accepted word; it clears on accept.
//    - Reaching WDOG_CYCLES sets wdog_err and forces state to PPS.
//    - Credits are not reset by a watchdog timeout.
//  SLICE_DEMUX_CTRL_WATCHDOG_EN undefined: no counter, wdog_err tied 0.
// TESTING
//  1. Reset release, s_valid=1 continuously -> 4 words with data_in_is_pps=1.
//     Then 1 in_sof cycle with in_valid=0, then data words.
//  2. chunk_size=100, slices=2, lines=2 (400 B) -> exactly 13 data words.
//     frame_done pulses 1 cycle after the 13th in_valid.
//  3. Hold fifo_pop=0, slices=2 -> s_ready drops once either credit reaches 1.
//     One pop on that slice re-raises s_ready next cycle.
//  4. demux_out_valid[0] and fifo_pop[0] both high for 5 cycles -> credit[0] unchanged; credit_err stays 0.
//  5. flush asserted mid-DATA -> next cycle in_valid=0, credits=16; PPS phase restarts.
//  6. WATCHDOG_EN, WDOG_CYCLES=8, s_valid=0 in DATA -> wdog_err=1 after 8 cycles; state is PPS.

Source files
------------

// File: rtl/slice_demux_ctrl.sv
// rtl/slice_demux_ctrl.sv - frame sequencer and credit-based flow control ahead of slice_demux
// Optional macro SLICE_DEMUX_CTRL_WATCHDOG_EN adds a DATA-state stall watchdog.
module slice_demux_ctrl #(
   parameter int MAX_NBR_SLICES = 2,
   parameter int FIFO_DEPTH     = 16,
   parameter int CREDIT_MARGIN  = 2,
   parameter int PPS_WORDS      = 4,
   parameter int WDOG_CYCLES    = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [9:0]                slices_per_line,
   input  logic [15:0]               chunk_size,
   input  logic [15:0]               lines_per_frame,
   input  logic [255:0]              s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [255:0]              in_data,
   output logic                      in_valid,
   output logic                      in_sof,
   output logic                      data_in_is_pps,
   input  logic [MAX_NBR_SLICES-1:0] demux_out_valid,
   input  logic [MAX_NBR_SLICES-1:0] fifo_pop,
   output logic                      frame_done,
   output logic                      credit_err,
   output logic                      wdog_err
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(PPS_WORDS + 1);

   typedef enum logic [2:0] {S_IDLE, S_PPS, S_SOF, S_DATA, S_DONE} state_t;

   state_t                    state, state_nxt;
   logic [CW-1:0]             credit [MAX_NBR_SLICES];
   logic [MAX_NBR_SLICES-1:0] sat_hit;
   logic [9:0]                slices_reg;
   logic [PW-1:0]             pps_cnt;
   logic [42:0]               byte_cnt;
   logic [41:0]               frame_bytes;
   logic                      clr, credit_ok, accept, last_pps, last_data, zero_frame, wdog_to;

   assign clr         = rst | flush;
   assign frame_bytes = 42'(chunk_size) * 42'(slices_reg) * 42'(lines_per_frame);
   assign zero_frame  = (frame_bytes == 42'd0);
   assign last_data   = (byte_cnt + 43'd32) >= {1'b0, frame_bytes};
   assign last_pps    = (pps_cnt == PW'(PPS_WORDS - 1));

   // Only the slices active on this line need headroom for the next word.
   always_comb begin
      credit_ok = 1'b1;
      for (int i = 0; i < MAX_NBR_SLICES; i++)
         if (10'(i) < slices_reg && credit[i] < CW'(CREDIT_MARGIN))
            credit_ok = 1'b0;
   end

   assign s_ready = ~clr & ((state == S_PPS) | ((state == S_DATA) & credit_ok));
   assign accept  = s_valid & s_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_PPS;
         S_PPS:  if (accept && last_pps) state_nxt = S_SOF;
         S_SOF:  state_nxt = zero_frame ? S_DONE : S_DATA;
         S_DATA: begin
            if (wdog_to)                    state_nxt = S_PPS;
            else if (accept && last_data)   state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_PPS;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state          <= S_IDLE;
         in_data        <= '0;
         in_valid       <= 1'b0;
         data_in_is_pps <= 1'b0;
         in_sof         <= 1'b0;
         frame_done     <= 1'b0;
         pps_cnt        <= '0;
         byte_cnt       <= '0;
         slices_reg     <= '0;
      end else begin
         state          <= state_nxt;
         in_valid       <= accept;
         data_in_is_pps <= accept & (state == S_PPS);
         if (accept) in_data <= s_data;
         in_sof         <= (state == S_SOF);
         frame_done     <= (state == S_DONE);
         if (state == S_IDLE || state == S_PPS)
            slices_reg <= (slices_per_line > 10'(MAX_NBR_SLICES)) ? 10'(MAX_NBR_SLICES) : slices_per_line;
         if (state != S_PPS) pps_cnt <= '0;
         else if (accept)    pps_cnt <= pps_cnt + PW'(1);
         if (state != S_DATA) byte_cnt <= '0;
         else if (accept)     byte_cnt <= byte_cnt + 43'd32;
      end
   end

   // A simultaneous push and pop cancel out and can never saturate.
   always_comb begin
      sat_hit = '0;
      for (int i = 0; i < MAX_NBR_SLICES; i++)
         sat_hit[i] = (demux_out_valid[i] & ~fifo_pop[i] & (credit[i] == '0)) |
                      (fifo_pop[i] & ~demux_out_valid[i] & (credit[i] == CW'(FIFO_DEPTH)));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_NBR_SLICES; i++) begin
         if (clr)
            credit[i] <= CW'(FIFO_DEPTH);
         else if (demux_out_valid[i] && !fifo_pop[i] && credit[i] != '0)
            credit[i] <= credit[i] - CW'(1);
         else if (fifo_pop[i] && !demux_out_valid[i] && credit[i] != CW'(FIFO_DEPTH))
            credit[i] <= credit[i] + CW'(1);
      end
      if (clr) credit_err <= 1'b0;
      else     credit_err <= credit_err | (|sat_hit);
   end

`ifdef SLICE_DEMUX_CTRL_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   assign wdog_to = (state == S_DATA) && !accept && (wdog_cnt == WW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (clr || state != S_DATA || accept) wdog_cnt <= '0;
      else                                  wdog_cnt <= wdog_cnt + WW'(1);
      if (clr)          wdog_err <= 1'b0;
      else if (wdog_to) wdog_err <= 1'b1;
   end
`else
   assign wdog_to  = 1'b0;
   assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_slice_demux_ctrl.sv
// tb/tb_slice_demux_ctrl.sv - randomized self-checking bench for slice_demux_ctrl
module tb_slice_demux_ctrl;
   localparam int NS    = 2;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           rst, flush;
   logic [9:0]     slices_per_line;
   logic [15:0]    chunk_size, lines_per_frame;
   logic [255:0]   s_data, in_data;
   logic           s_valid, s_ready, in_valid, in_sof, data_in_is_pps;
   logic [NS-1:0]  demux_out_valid, fifo_pop;
   logic           frame_done, credit_err, wdog_err;

   always #5 clk = ~clk;

   slice_demux_ctrl #(.MAX_NBR_SLICES(NS), .FIFO_DEPTH(DEPTH), .CREDIT_MARGIN(2),
                      .PPS_WORDS(4), .WDOG_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .slices_per_line(slices_per_line),
      .chunk_size(chunk_size), .lines_per_frame(lines_per_frame),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .data_in_is_pps(data_in_is_pps),
      .demux_out_valid(demux_out_valid), .fifo_pop(fifo_pop),
      .frame_done(frame_done), .credit_err(credit_err), .wdog_err(wdog_err));

   int           checks = 0, errors = 0, cyc = 0, to_send = 0;
   int           last_data_cyc, done_cyc;
   bit           gaps = 0, chk_ready = 0, seen;
   int           cred [NS];
   logic [255:0] sent_q [$], got_q [$];
   int           ev_q [$];   // 1 = PPS word, 2 = data word, 3 = sof, 4 = frame_done

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample the handshake before the edge, then update the reference and log outputs.
   task automatic tick();
      bit acc, exp_rdy;
      #1;
      acc = s_valid && s_ready;
      if (chk_ready) begin
         exp_rdy = 1'b1;
         for (int i = 0; i < NS; i++) if (cred[i] < 2) exp_rdy = 1'b0;
         check("s_ready_credit", s_ready, exp_rdy);
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (rst || flush)                              cred[i] = DEPTH;
         else if (demux_out_valid[i] && !fifo_pop[i])   cred[i] = (cred[i] > 0) ? cred[i] - 1 : 0;
         else if (fifo_pop[i] && !demux_out_valid[i])   cred[i] = (cred[i] < DEPTH) ? cred[i] + 1 : DEPTH;
      end
      if (acc) begin
         sent_q.push_back(s_data);
         to_send--;
         s_data = rnd256();
      end
      s_valid = (to_send > 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (in_valid) begin
         ev_q.push_back(data_in_is_pps ? 1 : 2);
         got_q.push_back(in_data);
         if (!data_in_is_pps) last_data_cyc = cyc;
      end
      if (in_sof) begin
         ev_q.push_back(3);
         check("sof_no_valid", in_valid, 0);
      end
      if (frame_done) begin
         ev_q.push_back(4);
         done_cyc = cyc;
      end
   endtask

   task automatic run_frame(input string tag, input int cs, input int sl, input int ln, input bit g);
      longint fb;
      int     nw, eff, exp_ev;
      chunk_size = 16'(cs); slices_per_line = 10'(sl); lines_per_frame = 16'(ln); gaps = g;
      eff = (sl > NS) ? NS : sl;
      fb  = longint'(cs) * eff * ln;
      nw  = int'((fb + 31) / 32);
      sent_q.delete(); got_q.delete(); ev_q.delete();
      last_data_cyc = -1; done_cyc = -1;
      to_send = 4 + nw; s_valid = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         tick();
         seen = frame_done;
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_event_count"}, ev_q.size(), 6 + nw);
      for (int k = 0; k < ev_q.size() && k < 6 + nw; k++) begin
         exp_ev = (k < 4) ? 1 : (k == 4) ? 3 : (k < 5 + nw) ? 2 : 4;
         check({tag, "_event_order"}, ev_q[k], exp_ev);
      end
      check({tag, "_word_count"}, got_q.size(), sent_q.size());
      for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
         check({tag, "_word_data"}, got_q[k], sent_q[k]);
      if (nw > 0) check({tag, "_done_latency"}, done_cyc, last_data_cyc + 1);
      gaps = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      slices_per_line = 10'd2; chunk_size = 16'd100; lines_per_frame = 16'd2;
      s_data = rnd256(); s_valid = 1'b0; demux_out_valid = '0; fifo_pop = '0;
      for (int i = 0; i < NS; i++) cred[i] = DEPTH;
      repeat (3) tick();
      check("rst_s_ready", s_ready, 0);
      check("rst_in_valid", in_valid, 0);
      check("rst_in_data", in_data, 0);
      check("rst_in_sof", in_sof, 0);
      check("rst_is_pps", data_in_is_pps, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_credit_err", credit_err, 0);
      check("rst_wdog_err", wdog_err, 0);
      rst = 1'b0;

      run_frame("f400", 100, 2, 2, 0);
      for (int r = 0; r < 3; r++)
         run_frame("frand", $urandom_range(1, 120), $urandom_range(1, 3), $urandom_range(1, 3), 1);
      run_frame("fzero", 64, 2, 0, 0);

      // Long frame so the credit scenarios run inside DATA.
      chunk_size = 16'd255; slices_per_line = 10'd2; lines_per_frame = 16'd16;
      to_send = 4 + 255; s_valid = 1'b1; seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         tick();
         seen = in_sof;
      end
      check("reach_data", seen, 1);
      chk_ready = 1'b1;
      demux_out_valid = 2'b01; fifo_pop = 2'b01;
      repeat (5) tick();
      check("push_pop_no_err", credit_err, 0);
      fifo_pop = 2'b00;
      repeat (15) tick();
      check("credit_low_stall", s_ready, 0);
      demux_out_valid = 2'b00; fifo_pop = 2'b01;
      tick();
      fifo_pop = 2'b00;
      check("credit_return_ready", s_ready, 1);
      demux_out_valid = 2'b01;
      repeat (3) tick();
      check("push_at_zero_err", credit_err, 1);
      demux_out_valid = 2'b00; fifo_pop = 2'b01;
      repeat (16) tick();
      fifo_pop = 2'b00;

      to_send = 0; s_valid = 1'b0;
      repeat (8) tick();
`ifdef SLICE_DEMUX_CTRL_WATCHDOG_EN
      check("wdog_set", wdog_err, 1);
      check("wdog_to_pps", s_ready, 1);
`else
      check("wdog_tied_low", wdog_err, 0);
      check("stall_stays_data", s_ready, 1);
`endif
      chk_ready = 1'b0;

      demux_out_valid = 2'b01;
      repeat (10) tick();
      demux_out_valid = 2'b00;
      to_send = 3; s_valid = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      check("flush_in_valid", in_valid, 0);
      check("flush_in_data", in_data, 0);
      check("flush_s_ready", s_ready, 0);
      check("flush_credit_err", credit_err, 0);
      to_send = 0; s_valid = 1'b0;
      flush = 1'b0;
      #1;
      check("flush_idle", s_ready, 0);
      tick();
      check("flush_pps_restart", s_ready, 1);
      fifo_pop = 2'b10;
      tick();
      fifo_pop = 2'b00;
      check("pop_at_depth_err", credit_err, 1);

      run_frame("fpost", 100, 2, 2, 0);

      chunk_size = 16'd255; slices_per_line = 10'd2; lines_per_frame = 16'd16;
      to_send = 4 + 255; s_valid = 1'b1; seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         tick();
         seen = in_sof;
      end
      check("reach_data_2", seen, 1);
      chk_ready = 1'b1;
      demux_out_valid = 2'b01;
      repeat (15) tick();
      check("flush_credit_full", s_ready, 0);
      demux_out_valid = 2'b00;
      chk_ready = 1'b0;
      to_send = 0; s_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
